alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Initiator side of the Gumnut ALU interface. Accepts one decoded ALU/shift request,
//  drives the combinational ALU for ops 0000-0111, and runs shifts/rotates (1000-1011) itself.
//  Holds the architectural C/Z flag register and presents one result to register-file writeback.
//  Sits between the decode stage and the register file.
// PARAMETERS
//  none (data width fixed at 8, count width at 3, register index width at 3)
// PORTS
//  clk_i        in   1  clock, all state on rising edge
//  rst_ni       in   1  asynchronous, active-low reset
//  req_valid_i  in   1  request valid
//  req_ready_o  out  1  sequencer can accept (high only in IDLE)
//  req_op_i     in   4  ALUOp encoding (0000 add .. 0111 and-not, 1000 shl, 1001 shr, 1010 rol, 1011 ror)
//  req_rs_i     in   8  first operand
//  req_op2_i    in   8  second operand (register or immediate)
//  req_count_i  in   3  shift/rotate amount
//  req_rd_i     in   3  destination register index
//  alu_op_o     out  4  ALUOp to ALU
//  alu_rs_o     out  8  operand to ALU
//  alu_op2_o    out  8  operand to ALU
//  alu_carry_o  out  1  current C flag to ALU (for addc/subc)
//  alu_res_i    in   8  ALU result
//  alu_carry_i  in   1  ALU carry/borrow out
//  alu_zero_i   in   1  ALU zero out (informational; Z is recomputed from the result)
//  wb_valid_o   out  1  result valid
//  wb_ready_i   in   1  writeback accepts
//  wb_rd_o      out  3  destination index
//  wb_data_o    out  8  result
//  wb_we_o      out  1  write enable = (rd != 0); r0 is never written
//  flag_c_o     out  1  C flag register
//  flag_z_o     out  1  Z flag register
// BEHAVIOUR
//  Reset: state IDLE; req_ready_o=1; every other output, all operand/result registers and C/Z = 0.
//  FSM: IDLE -> EXEC (op[3]=0) | SHIFT (op 10xx) | EXEC (op 11xx); EXEC -> RESP; SHIFT -> RESP when done;
//   RESP -> IDLE on wb_valid_o & wb_ready_i.
//  Accept: req_valid_i & req_ready_o at edge N latches op/rs/op2/count/rd.
//  EXEC: alu_* outputs driven from latched request for exactly this cycle, else 0;
//   result<=alu_res_i, C<=alu_carry_i, Z<=(alu_res_i==0). wb_valid_o first high in cycle N+2.
//  Op 11xx (undefined): ALU not used; result=0, C=0, Z=1, same timing as EXEC.
//  SHIFT: one bit position per cycle, count register decrements; lasts max(count,1) cycles.
//   shl: 0 in at bit0; shr: 0 in at bit7; rol/ror: wrap-around. C = last bit shifted out.
//   count=0: result=rs, C unchanged, Z=(rs==0), one SHIFT cycle.
//   wb_valid_o first high in cycle N+1+max(count,1).
//  Flags C/Z update only on entry to RESP; stable otherwise.
//  RESP: wb_valid_o=1, wb_rd_o/wb_data_o/wb_we_o held stable until the handshake; no new request accepted.
//  req_valid_i outside IDLE is ignored; the requester holds it.
//  Async reset in any state aborts the operation; nothing is written back; flags return to 0.
// CONFIGURATION
//  ALU_SEQ_FAST_SHIFT_EN defined: SHIFT is always exactly one cycle using a barrel shifter
//   (same result/C/Z rules, count=0 included); wb_valid_o first high at N+2 for all ops.
//  Not defined: iterative shifter as above.
// TESTING
//  C=0, add 0xF0+0x20, rd=3 -> wb_data=0x10, wb_we=1, C=1, Z=0, wb_valid at N+2.
//  sub 0x05-0x05 -> wb_data=0x00, C=0, Z=1; then addc 0x01+0x01 with C=1 -> 0x03, alu_carry_o=1 in EXEC.
//  shl 0x81 count=1 -> 0x02, C=1 at N+2; ror 0x01 count=3 -> 0x20, C=0 at N+4 (N+2 with FAST_SHIFT).
//  rd=0 add 0x01+0x01 -> wb_we=0, flags still updated (C=0, Z=0).
//  wb_ready_i low for 5 cycles in RESP -> wb_valid/wb_data stable, req_ready_o=0, second request held.
//  rst_ni low mid-SHIFT (rol, count=7) -> IDLE, wb_valid_o=0, C=Z=0; next request completes normally.

Source files
------------

// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//
// Purpose:
//   Initiator side of the Gumnut ALU interface. It takes one decoded ALU or
//   shift request at a time. Ops 0000-0111 go to the external combinational
//   ALU for a single cycle. Shifts and rotates (10xx) run inside this block.
//   Ops 11xx are undefined and produce result 0 with C=0 and Z=1. The block
//   holds the architectural C/Z flags and presents one result at a time to
//   register-file writeback.
//
// Configuration macro:
//   ALU_SEQ_FAST_SHIFT_EN - when defined, every shift/rotate finishes in one
//                           cycle using a barrel shifter. When undefined, the
//                           shifter moves one bit position per cycle.
//
// Ports:
//   clk_i, rst_ni           clock and asynchronous active-low reset
//   req_valid_i/ready_o     request handshake (ready only while idle)
//   req_op_i/rs_i/op2_i     ALUOp and operands
//   req_count_i             shift/rotate amount
//   req_rd_i                destination register index
//   alu_op_o/rs_o/op2_o     operands to the external ALU (valid in EXEC only)
//   alu_carry_o             current C flag to the ALU (valid in EXEC only)
//   alu_res_i/carry_i       ALU result and carry/borrow out
//   alu_zero_i              ALU zero out (ignored; Z is taken from the result)
//   wb_valid_o/ready_i      writeback handshake
//   wb_rd_o/data_o/we_o     writeback index, data and write enable (rd != 0)
//   flag_c_o, flag_z_o      architectural C and Z flags
// ---------------------------------------------------------------------------
module alu_sequencer (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [3:0] req_op_i,
    input  logic [7:0] req_rs_i,
    input  logic [7:0] req_op2_i,
    input  logic [2:0] req_count_i,
    input  logic [2:0] req_rd_i,
    output logic [3:0] alu_op_o,
    output logic [7:0] alu_rs_o,
    output logic [7:0] alu_op2_o,
    output logic       alu_carry_o,
    input  logic [7:0] alu_res_i,
    input  logic       alu_carry_i,
    input  logic       alu_zero_i,
    output logic       wb_valid_o,
    input  logic       wb_ready_i,
    output logic [2:0] wb_rd_o,
    output logic [7:0] wb_data_o,
    output logic       wb_we_o,
    output logic       flag_c_o,
    output logic       flag_z_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_op;
    logic [7:0]  r_rs;
    logic [7:0]  r_op2;
    logic [2:0]  r_count;
    logic [2:0]  r_rd;
    logic [7:0]  r_result;
    logic        r_c;
    logic        r_z;
    logic        w_accept;
    logic        w_exec_z;

    // One bit position of shift/rotate. kind: 00 shl, 01 shr, 10 rol, 11 ror.
    // Returns {bit shifted out, new value}.
    function automatic logic [8:0] shift_step(input logic [1:0] kind,
                                              input logic [7:0] v);
        logic [8:0] r;
        case (kind)
            2'b00:   r = {v[7], v[6:0], 1'b0};
            2'b01:   r = {v[0], 1'b0, v[7:1]};
            2'b10:   r = {v[7], v[6:0], v[7]};
            default: r = {v[0], v[0], v[7:1]};
        endcase
        return r;
    endfunction

`ifdef ALU_SEQ_FAST_SHIFT_EN
    // Unrolled shifter: applies up to seven single steps. With cnt=0 the
    // value passes through and the incoming carry is kept.
    function automatic logic [8:0] shift_n(input logic [1:0] kind,
                                           input logic [7:0] v,
                                           input logic [2:0] cnt,
                                           input logic       cin);
        logic [8:0] r;
        r = {cin, v};
        for (int i = 0; i < 7; i++) begin
            if (3'(i) < cnt)
                r = shift_step(kind, r[7:0]);
        end
        return r;
    endfunction

    logic [8:0] w_shift;
    assign w_shift = shift_n(r_op[1:0], r_rs, r_count, r_c);
`else
    logic [7:0] r_work;
    logic [8:0] w_step;
    assign w_step = shift_step(r_op[1:0], r_work);
`endif

    assign w_accept = req_valid_i && (r_state == IDLE);
    // The ALU's zero output is deliberately ignored; the AND with 0 only
    // keeps the port referenced.
    assign w_exec_z = (alu_res_i == 8'h00) | (alu_zero_i & 1'b0);

    assign flag_c_o = r_c;
    assign flag_z_o = r_z;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_op     <= '0;
            r_rs     <= '0;
            r_op2    <= '0;
            r_count  <= '0;
            r_rd     <= '0;
            r_result <= '0;
            r_c      <= 1'b0;
            r_z      <= 1'b0;
`ifndef ALU_SEQ_FAST_SHIFT_EN
            r_work   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op    <= req_op_i;
                        r_rs    <= req_rs_i;
                        r_op2   <= req_op2_i;
                        r_count <= req_count_i;
                        r_rd    <= req_rd_i;
`ifndef ALU_SEQ_FAST_SHIFT_EN
                        r_work  <= req_rs_i;
`endif
                    end
                end
                EXEC: begin
                    if (r_op[3]) begin
                        // Undefined 11xx ops: fixed result, ALU untouched.
                        r_result <= 8'h00;
                        r_c      <= 1'b0;
                        r_z      <= 1'b1;
                    end else begin
                        r_result <= alu_res_i;
                        r_c      <= alu_carry_i;
                        r_z      <= w_exec_z;
                    end
                end
                SHIFT: begin
`ifdef ALU_SEQ_FAST_SHIFT_EN
                    r_result <= w_shift[7:0];
                    r_c      <= w_shift[8];
                    r_z      <= (w_shift[7:0] == 8'h00);
`else
                    if (r_count == 3'd0) begin
                        // Zero count: pass rs through and keep C.
                        r_result <= r_work;
                        r_z      <= (r_work == 8'h00);
                    end else if (r_count == 3'd1) begin
                        // Last step: flags are committed as RESP is entered.
                        r_result <= w_step[7:0];
                        r_c      <= w_step[8];
                        r_z      <= (w_step[7:0] == 8'h00);
                    end else begin
                        r_work  <= w_step[7:0];
                        r_count <= r_count - 3'd1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready_o = 1'b0;
        alu_op_o    = '0;
        alu_rs_o    = '0;
        alu_op2_o   = '0;
        alu_carry_o = 1'b0;
        wb_valid_o  = 1'b0;
        wb_rd_o     = '0;
        wb_data_o   = '0;
        wb_we_o     = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i)
                    w_state_nxt = (req_op_i[3:2] == 2'b10) ? SHIFT : EXEC;
            end
            EXEC: begin
                if (!r_op[3]) begin
                    alu_op_o    = r_op;
                    alu_rs_o    = r_rs;
                    alu_op2_o   = r_op2;
                    alu_carry_o = r_c;
                end
                w_state_nxt = RESP;
            end
            SHIFT: begin
`ifdef ALU_SEQ_FAST_SHIFT_EN
                w_state_nxt = RESP;
`else
                if (r_count <= 3'd1)
                    w_state_nxt = RESP;
`endif
            end
            RESP: begin
                wb_valid_o = 1'b1;
                wb_rd_o    = r_rd;
                wb_data_o  = r_result;
                wb_we_o    = (r_rd != 3'd0);
                if (wb_ready_i)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
//
// Purpose:
//   Self-checking bench for alu_sequencer. A small combinational Gumnut ALU
//   model is connected to the alu_* ports. A table of directed requests
//   gives the expected writeback data, write enable, flags and latency for
//   each request. Hand-written sequences cover writeback back-pressure and
//   reset in the middle of a shift.
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid, req_ready;
    logic [3:0] req_op;
    logic [7:0] req_rs, req_op2;
    logic [2:0] req_count, req_rd;
    logic [3:0] alu_op;
    logic [7:0] alu_rs, alu_op2, alu_res;
    logic       alu_cin, alu_cout, alu_zero;
    logic       wb_valid, wb_ready, wb_we;
    logic [2:0] wb_rd;
    logic [7:0] wb_data;
    logic       flag_c, flag_z;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_sequencer dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_op_i    (req_op),
        .req_rs_i    (req_rs),
        .req_op2_i   (req_op2),
        .req_count_i (req_count),
        .req_rd_i    (req_rd),
        .alu_op_o    (alu_op),
        .alu_rs_o    (alu_rs),
        .alu_op2_o   (alu_op2),
        .alu_carry_o (alu_cin),
        .alu_res_i   (alu_res),
        .alu_carry_i (alu_cout),
        .alu_zero_i  (alu_zero),
        .wb_valid_o  (wb_valid),
        .wb_ready_i  (wb_ready),
        .wb_rd_o     (wb_rd),
        .wb_data_o   (wb_data),
        .wb_we_o     (wb_we),
        .flag_c_o    (flag_c),
        .flag_z_o    (flag_z)
    );

    // Gumnut ALU: add, addc, sub, subc, and, or, xor, and-not (mask).
    // Carry on subtract is the borrow.
    logic [8:0] alu_full;
    always_comb begin
        alu_full = '0;
        case (alu_op)
            4'd0: alu_full = {1'b0, alu_rs} + {1'b0, alu_op2};
            4'd1: alu_full = {1'b0, alu_rs} + {1'b0, alu_op2} + {8'b0, alu_cin};
            4'd2: alu_full = {1'b0, alu_rs} - {1'b0, alu_op2};
            4'd3: alu_full = {1'b0, alu_rs} - {1'b0, alu_op2} - {8'b0, alu_cin};
            4'd4: alu_full = {1'b0, alu_rs & alu_op2};
            4'd5: alu_full = {1'b0, alu_rs | alu_op2};
            4'd6: alu_full = {1'b0, alu_rs ^ alu_op2};
            4'd7: alu_full = {1'b0, alu_rs & ~alu_op2};
            default: alu_full = '0;
        endcase
    end
    assign alu_res  = alu_full[7:0];
    assign alu_cout = alu_full[8];
    assign alu_zero = (alu_full[7:0] == 8'h00);

    typedef struct {
        logic [3:0] op;
        logic [7:0] rs;
        logic [7:0] op2;
        logic [2:0] cnt;
        logic [2:0] rd;
        int         lat;   // edges from acceptance to wb_valid (iterative)
        logic       cin;   // C expected on alu_carry_o during EXEC
        logic [7:0] data;
        logic       we;
        logic       c;
        logic       z;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic [3:0] op, input logic [7:0] rs,
                                input logic [7:0] op2, input logic [2:0] cnt,
                                input logic [2:0] rd, input int lat,
                                input logic cin, input logic [7:0] data,
                                input logic we, input logic c, input logic z);
        vec_t v;
        v.op = op; v.rs = rs; v.op2 = op2; v.cnt = cnt; v.rd = rd;
        v.lat = lat; v.cin = cin; v.data = data; v.we = we; v.c = c; v.z = z;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives a request at a falling edge and returns #1 after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [7:0] rs,
                         input logic [7:0] op2, input logic [2:0] cnt,
                         input logic [2:0] rd);
        int g;
        @(negedge clk);
        req_op = op; req_rs = rs; req_op2 = op2; req_count = cnt; req_rd = rd;
        req_valid = 1'b1;
        g = 0;
        while (!req_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Counts rising edges until wb_valid is high; bounded.
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!wb_valid && n < 30);
        if (!wb_valid) check("wb_valid_timeout", 0, 1);
    endtask

    initial begin
        int n;
        int exp_lat;
        vec_t v;

        req_valid = 1'b0; req_op = '0; req_rs = '0; req_op2 = '0;
        req_count = '0; req_rd = '0; wb_ready = 1'b1;

        //          op    rs     op2    cnt  rd  lat cin data   we c  z
        vecs[0]  = mk(4'h0, 8'hF0, 8'h20, 3'd0, 3'd3, 1, 0, 8'h10, 1, 1, 0);
        vecs[1]  = mk(4'h2, 8'h05, 8'h05, 3'd0, 3'd1, 1, 1, 8'h00, 1, 0, 1);
        vecs[2]  = mk(4'h0, 8'hFF, 8'h01, 3'd0, 3'd2, 1, 0, 8'h00, 1, 1, 1);
        vecs[3]  = mk(4'h1, 8'h01, 8'h01, 3'd0, 3'd4, 1, 1, 8'h03, 1, 0, 0);
        vecs[4]  = mk(4'h8, 8'h81, 8'h00, 3'd1, 3'd5, 1, 0, 8'h02, 1, 1, 0);
        vecs[5]  = mk(4'hB, 8'h01, 8'h00, 3'd3, 3'd6, 3, 0, 8'h20, 1, 0, 0);
        vecs[6]  = mk(4'h0, 8'h01, 8'h01, 3'd0, 3'd0, 1, 0, 8'h02, 0, 0, 0);
        vecs[7]  = mk(4'h9, 8'h01, 8'h00, 3'd1, 3'd1, 1, 0, 8'h00, 1, 1, 1);
        vecs[8]  = mk(4'h8, 8'h00, 8'h00, 3'd0, 3'd2, 1, 0, 8'h00, 1, 1, 1);
        vecs[9]  = mk(4'hC, 8'h55, 8'hAA, 3'd0, 3'd7, 1, 0, 8'h00, 1, 0, 1);
        vecs[10] = mk(4'hA, 8'h96, 8'h00, 3'd2, 3'd3, 2, 0, 8'h5A, 1, 0, 0);
        vecs[11] = mk(4'h2, 8'h03, 8'h05, 3'd0, 3'd1, 1, 0, 8'hFE, 1, 1, 0);
        vecs[12] = mk(4'h3, 8'h10, 8'h01, 3'd0, 3'd2, 1, 1, 8'h0E, 1, 0, 0);
        vecs[13] = mk(4'h9, 8'h80, 8'h00, 3'd7, 3'd2, 7, 0, 8'h01, 1, 0, 0);
        vecs[14] = mk(4'hA, 8'h80, 8'h00, 3'd1, 3'd7, 1, 0, 8'h01, 1, 1, 0);
        vecs[15] = mk(4'h8, 8'h7E, 8'h00, 3'd0, 3'd3, 1, 0, 8'h7E, 1, 1, 0);
        vecs[16] = mk(4'h6, 8'hAA, 8'hAA, 3'd0, 3'd3, 1, 1, 8'h00, 1, 0, 1);
        vecs[17] = mk(4'h7, 8'hF0, 8'h30, 3'd0, 3'd4, 1, 0, 8'hC0, 1, 0, 0);
        vecs[18] = mk(4'h5, 8'h0F, 8'h30, 3'd0, 3'd5, 1, 0, 8'h3F, 1, 0, 0);
        vecs[19] = mk(4'h4, 8'hF0, 8'h3C, 3'd0, 3'd6, 1, 0, 8'h30, 1, 0, 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 1);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_flag_c", flag_c, 0);
        check("rst_flag_z", flag_z, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_wb_data", wb_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
`ifdef ALU_SEQ_FAST_SHIFT_EN
            exp_lat = 1;
`else
            exp_lat = v.lat;
`endif
            issue(v.op, v.rs, v.op2, v.cnt, v.rd);
            if (!v.op[3]) begin
                check($sformatf("v%0d_alu_op", i), alu_op, v.op);
                check($sformatf("v%0d_alu_rs", i), alu_rs, v.rs);
                check($sformatf("v%0d_alu_op2", i), alu_op2, v.op2);
                check($sformatf("v%0d_alu_cin", i), alu_cin, v.cin);
            end else begin
                check($sformatf("v%0d_alu_idle", i), {alu_op, alu_rs, alu_op2}, 0);
            end
            wait_valid(n);
            check($sformatf("v%0d_latency", i), n, exp_lat);
            check($sformatf("v%0d_wb_data", i), wb_data, v.data);
            check($sformatf("v%0d_wb_rd", i), wb_rd, v.rd);
            check($sformatf("v%0d_wb_we", i), wb_we, v.we);
            check($sformatf("v%0d_flag_c", i), flag_c, v.c);
            check($sformatf("v%0d_flag_z", i), flag_z, v.z);
            check($sformatf("v%0d_ready_in_resp", i), req_ready, 0);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_wb_released", i), wb_valid, 0);
        end

        // Back-pressure: result held for 5 cycles, second request waits
        @(negedge clk);
        wb_ready = 1'b0;
        issue(4'h0, 8'h11, 8'h22, 3'd0, 3'd5);
        wait_valid(n);
        check("stall_first_data", wb_data, 8'h33);
        @(negedge clk);
        req_op = 4'h6; req_rs = 8'h0F; req_op2 = 8'hF0; req_count = 3'd0;
        req_rd = 3'd6; req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("stall_wb_valid", wb_valid, 1);
            check("stall_wb_data", wb_data, 8'h33);
            check("stall_wb_rd", wb_rd, 3'd5);
            check("stall_req_ready", req_ready, 0);
        end
        @(negedge clk);
        wb_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_released", wb_valid, 0);
        check("stall_idle_ready", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("stall_second_exec_op", alu_op, 4'h6);
        wait_valid(n);
        check("stall_second_latency", n, 1);
        check("stall_second_data", wb_data, 8'hFF);
        check("stall_second_rd", wb_rd, 3'd6);
        @(posedge clk);
        #1;

        // Reset during a long rotate
        issue(4'h0, 8'hFF, 8'h01, 3'd0, 3'd1);
        wait_valid(n);
        check("pre_reset_flag_c", flag_c, 1);
        check("pre_reset_flag_z", flag_z, 1);
        @(posedge clk);
        #1;
        issue(4'hA, 8'h81, 8'h00, 3'd7, 3'd1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", req_ready, 1);
        check("mid_rst_wb_valid", wb_valid, 0);
        check("mid_rst_wb_we", wb_we, 0);
        check("mid_rst_flag_c", flag_c, 0);
        check("mid_rst_flag_z", flag_z, 0);
        @(posedge clk);
        #1;
        check("mid_rst_held_valid", wb_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(4'h0, 8'h01, 8'h02, 3'd0, 3'd2);
        wait_valid(n);
        check("post_rst_latency", n, 1);
        check("post_rst_data", wb_data, 8'h03);
        check("post_rst_we", wb_we, 1);
        check("post_rst_flag_c", flag_c, 0);
        check("post_rst_flag_z", flag_z, 0);
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
